// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM encoding, channel select level and default frame geometry.
// Reused by the rx frontend and the matching tx backend.
package i2s_pkg;

  localparam int unsigned I2S_DATA_W = 16;
  localparam int unsigned I2S_SLOT_W = 32;

  localparam logic LRCK_LEFT = 1'b0;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with registered rise/fall pulses
// derived from the synchronised level.
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/i2s_rx_frontend.sv
// I2S slave receiver: synchronises bclk/lrck/sdata into clk, deserialises left/right
// words and emits each complete stereo frame with a one-cycle valid strobe.
module i2s_rx_frontend
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = I2S_DATA_W,
  parameter int unsigned SLOT_W      = I2S_SLOT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(SLOT_W + 1);

  logic w_bclk_sync, w_bclk_rise, w_bclk_fall;
  logic w_lrck, w_lrck_rise, w_lrck_fall;
  logic w_sdata, w_sdata_rise, w_sdata_fall;
  logic w_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .rst(rst), .i_async(i2s_bclk),
    .o_sync(w_bclk_sync), .o_rise(w_bclk_rise), .o_fall(w_bclk_fall)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk(clk), .rst(rst), .i_async(i2s_lrck),
    .o_sync(w_lrck), .o_rise(w_lrck_rise), .o_fall(w_lrck_fall)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst(rst), .i_async(i2s_sdata),
    .o_sync(w_sdata), .o_rise(w_sdata_rise), .o_fall(w_sdata_fall)
  );

  assign w_unused = ^{w_bclk_sync, w_bclk_fall, w_lrck_rise, w_lrck_fall,
                      w_sdata_rise, w_sdata_fall};

  logic              r_lrck_q;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [DATA_W-1:0] r_hold_l;
  logic              w_slot_edge;
  logic              w_slot_ok;

  i2s_state_e r_state, w_state_nxt;
  logic       w_valid_nxt, w_err_nxt, w_hold_ld;

  // The bit on the edge-detecting bclk rise still belongs to the closing slot.
  assign w_slot_edge = (w_lrck != r_lrck_q);
  assign w_cnt_inc   = (r_bit_cnt == CNT_W'(SLOT_W)) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
  assign w_shreg_nxt = (r_bit_cnt < CNT_W'(DATA_W)) ? {r_shreg[DATA_W-2:0], w_sdata} : r_shreg;
  assign w_slot_ok   = (w_cnt_inc >= CNT_W'(DATA_W));

  // Slot bit counter and shift register; both restart at every slot edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lrck_q  <= 1'b0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (w_bclk_rise) begin
      r_lrck_q <= w_lrck;
      if (w_slot_edge) begin
        r_bit_cnt <= '0;
        r_shreg   <= '0;
      end else begin
        r_bit_cnt <= w_cnt_inc;
        r_shreg   <= w_shreg_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ARM;
      r_hold_l     <= '0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      sample_valid <= w_valid_nxt;
      frame_err    <= w_err_nxt;
      if (w_hold_ld) begin
        r_hold_l <= w_shreg_nxt;
      end
      if (w_valid_nxt) begin
        sample_l <= r_hold_l;
        sample_r <= w_shreg_nxt;
      end
    end
  end

  // Frame sequencing: only slot edges move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_hold_ld   = 1'b0;
    if (w_bclk_rise && w_slot_edge) begin
      case (r_state)
        ST_ARM: begin
          if (w_lrck == LRCK_LEFT) begin
            w_state_nxt = ST_LEFT;
          end
        end
        ST_LEFT: begin
          if (w_lrck != LRCK_LEFT) begin
            if (w_slot_ok) begin
              w_hold_ld   = 1'b1;
              w_state_nxt = ST_RIGHT;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_ARM;
            end
          end
        end
        ST_RIGHT: begin
          if (w_lrck == LRCK_LEFT) begin
            w_state_nxt = ST_LEFT;
            if (w_slot_ok) begin
              w_valid_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: a slot-level frame model predicts valid/error
// events and output words; a per-cycle monitor compares the DUT against it.
module tb_i2s_rx_frontend;

  localparam int unsigned HALF = 8;  // clk cycles per bclk half period (clk = 16x bclk)
  localparam int unsigned LAT  = 4;  // SYNC_STAGES + 2

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        sdata = 1'b0;
  logic [15:0] sample_l, sample_r;
  logic        sample_valid, frame_err;

  i2s_rx_frontend dut (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // ev: 0 none, 1 valid frame, 2 frame error
  typedef struct { bit lvl; bit b; bit [1:0] ev; bit [15:0] el; bit [15:0] er; } pair_t;
  typedef struct { int unsigned due; bit [1:0] ev; bit [15:0] el; bit [15:0] er; } exp_t;

  pair_t       stream[$];
  exp_t        expq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned pos_cnt = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_l = '0;
  logic [15:0] exp_r = '0;

  bit          m_lvl = 1'b0;
  int          m_len = 0;
  bit [15:0]   m_word = '0;
  bit          m_armed = 1'b0;
  bit          m_held = 1'b0;
  bit [15:0]   m_hold = '0;

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Slot-level model: decides at each lrck change what the closed slot produces.
  task automatic add_slot(input bit lvl, input int n, input bit [15:0] w);
    bit [1:0]  ev;
    bit [15:0] el, er;
    bit        b;
    pair_t     p;
    if (lvl != m_lvl) begin
      ev = 2'd0; el = '0; er = '0;
      if (m_lvl == 1'b0) begin
        if (m_armed) begin
          if (m_len >= 16) begin m_hold = m_word; m_held = 1'b1; end
          else begin ev = 2'd2; m_armed = 1'b0; end
        end
      end else begin
        if (m_armed && m_held) begin
          if (m_len >= 16) begin ev = 2'd1; el = m_hold; er = m_word; end
          else ev = 2'd2;
        end
        m_held = 1'b0;
      end
      if (ev != 2'd0 && stream.size() > 0) begin
        p = stream.pop_back();
        p.ev = ev; p.el = el; p.er = er;
        stream.push_back(p);
      end
      m_lvl = lvl; m_len = 0; m_word = '0;
      if (lvl == 1'b0) m_armed = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      b = (i < 16) ? w[15-i] : 1'b0;
      if (m_len < 16) m_word = {m_word[14:0], b};
      m_len++;
      p.lvl = lvl; p.b = b; p.ev = 2'd0; p.el = '0; p.er = '0;
      stream.push_back(p);
    end
  endtask

  // Plays all but the last queued bit; lrck leads data by one bclk as in I2S.
  task automatic play();
    pair_t p;
    exp_t  e;
    while (stream.size() > 1) begin
      p = stream.pop_front();
      @(negedge clk);
      bclk = 1'b0; sdata = p.b; lrck = stream[0].lvl;
      repeat (HALF) @(negedge clk);
      bclk = 1'b1;
      if (p.ev != 2'd0) begin
        e.due = pos_cnt + LAT; e.ev = p.ev; e.el = p.el; e.er = p.er;
        expq.push_back(e);
      end
      repeat (HALF - 1) @(negedge clk);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    bclk = 1'b0; rst = 1'b1;
    stream.delete(); expq.delete();
    m_lvl = 1'b0; m_len = 0; m_word = '0; m_armed = 1'b0; m_held = 1'b0; m_hold = '0;
    exp_l = '0; exp_r = '0;
    #1;
    lit("reset_l", 32'(sample_l), 32'h0);
    lit("reset_r", 32'(sample_r), 32'h0);
    lit("reset_pulses", 32'({sample_valid, frame_err}), 32'h0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Per-cycle monitor against the model's expected events and held outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      pos_cnt++;
      #1;
      if (expq.size() > 0 && expq[0].due == pos_cnt) begin
        e = expq.pop_front();
        checks++;
        if (sample_valid !== (e.ev == 2'd1) || frame_err !== (e.ev == 2'd2)) begin
          failures++;
          $display("FAIL event @%0d: got valid=%b err=%b want ev=%0d",
                   pos_cnt, sample_valid, frame_err, e.ev);
        end
        if (e.ev == 2'd1) begin exp_l = e.el; exp_r = e.er; end
      end else begin
        checks++;
        if (sample_valid !== 1'b0 || frame_err !== 1'b0) begin
          failures++;
          $display("FAIL pulse @%0d: got valid=%b err=%b want 0 0",
                   pos_cnt, sample_valid, frame_err);
        end
      end
      checks++;
      if (sample_l !== exp_l || sample_r !== exp_r) begin
        failures++;
        $display("FAIL data @%0d: got l=%h r=%h want l=%h r=%h",
                 pos_cnt, sample_l, sample_r, exp_l, exp_r);
      end
      if (sample_valid === 1'b1) valid_cnt++;
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  initial begin
    int v0, e0;
    bit [15:0] lw;

    // 1: basic frame after reset
    do_reset(20);
    v0 = valid_cnt; e0 = err_cnt;
    add_slot(1'b0, 32, 16'h7FFF); add_slot(1'b1, 32, 16'h8001);
    add_slot(1'b0, 32, 16'h7FFF); add_slot(1'b1, 32, 16'h8001);
    add_slot(1'b0, 32, 16'h0101);
    play();
    lit("t1_l", 32'(sample_l), 32'h7FFF);
    lit("t1_r", 32'(sample_r), 32'h8001);
    lit("t1_valids", 32'(valid_cnt - v0), 32'd1);
    lit("t1_errs", 32'(err_cnt - e0), 32'd0);

    // 2: eight streamed frames
    v0 = valid_cnt; e0 = err_cnt;
    for (int n = 1; n <= 8; n++) begin
      lw = 16'(n * 16'h0101);
      add_slot(1'b1, 32, ~lw);
      add_slot(1'b0, 32, (n < 8) ? 16'((n + 1) * 16'h0101) : 16'h0000);
    end
    play();
    lit("t2_valids", 32'(valid_cnt - v0), 32'd8);
    lit("t2_errs", 32'(err_cnt - e0), 32'd0);
    lit("t2_l", 32'(sample_l), 32'h0808);
    lit("t2_r", 32'(sample_r), 32'hF7F7);

    // 3: stream begins mid right slot
    do_reset(5);
    v0 = valid_cnt; e0 = err_cnt;
    add_slot(1'b1, 12, 16'hFFFF);
    add_slot(1'b0, 32, 16'h1234); add_slot(1'b1, 32, 16'h5678);
    add_slot(1'b0, 32, 16'h9ABC);
    play();
    lit("t3_valids", 32'(valid_cnt - v0), 32'd1);
    lit("t3_errs", 32'(err_cnt - e0), 32'd0);
    lit("t3_l", 32'(sample_l), 32'h1234);
    lit("t3_r", 32'(sample_r), 32'h5678);

    // 4: short left slot
    v0 = valid_cnt; e0 = err_cnt;
    add_slot(1'b1, 32, 16'h1111);
    add_slot(1'b0, 10, 16'h2222); add_slot(1'b1, 32, 16'h3333);
    add_slot(1'b0, 32, 16'h4444); add_slot(1'b1, 32, 16'h5555);
    add_slot(1'b0, 40, 16'hA5A5);
    play();
    lit("t4_valids", 32'(valid_cnt - v0), 32'd2);
    lit("t4_errs", 32'(err_cnt - e0), 32'd1);
    lit("t4_l", 32'(sample_l), 32'h4444);
    lit("t4_r", 32'(sample_r), 32'h5555);

    // 5: long (40 bclk) left slot accepted
    v0 = valid_cnt; e0 = err_cnt;
    add_slot(1'b1, 32, 16'h0F0F);
    add_slot(1'b0, 32, 16'h0000);
    play();
    lit("t5_valids", 32'(valid_cnt - v0), 32'd1);
    lit("t5_errs", 32'(err_cnt - e0), 32'd0);
    lit("t5_l", 32'(sample_l), 32'hA5A5);
    lit("t5_r", 32'(sample_r), 32'h0F0F);

    // 6: reset in the middle of a right slot
    add_slot(1'b1, 10, 16'hCAFE);
    play();
    do_reset(3);
    v0 = valid_cnt; e0 = err_cnt;
    add_slot(1'b1, 22, 16'h0000);
    add_slot(1'b0, 32, 16'hBEEF); add_slot(1'b1, 32, 16'hF00D);
    add_slot(1'b0, 32, 16'h0000);
    play();
    lit("t6_valids", 32'(valid_cnt - v0), 32'd1);
    lit("t6_errs", 32'(err_cnt - e0), 32'd0);
    lit("t6_l", 32'(sample_l), 32'hBEEF);
    lit("t6_r", 32'(sample_r), 32'hF00D);

    repeat (20) @(negedge clk);
    lit("pending_events", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
